fourbit_ripple: RTL and testbench

FOURBIT_RIPPLE -- requirements
Module: fourbit_ripple

---
 rtl/fourbit_ripple_pkg.sv | 12 +
 rtl/fourbit_ripple_full_adder.sv | 17 +
 rtl/fourbit_ripple.sv | 52 +++++
 tb/tb_fourbit_ripple.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fourbit_ripple_pkg.sv
// Shared constants for the 4-bit ripple-carry adder.
// Holds the operand width and the register-stage reset values.
package fourbit_ripple_pkg;

  localparam int ADDER_WIDTH = 4;

  localparam logic [ADDER_WIDTH-1:0] SUM_RST  = '0;
  localparam logic                   COUT_RST = 1'b0;
  localparam logic                   OVF_RST  = 1'b0;
  localparam logic                   ZERO_RST = 1'b1;

endpackage

// File: rtl/fourbit_ripple_full_adder.sv
// Single-bit full adder.
// One stage of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/fourbit_ripple.sv
// 4-bit ripple-carry adder with combinational outputs
// and a one-cycle registered copy plus zero flag.
module fourbit_ripple
  import fourbit_ripple_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDER_WIDTH-1:0] X,
  input  logic [ADDER_WIDTH-1:0] Y,
  input  logic                   Cin,
  output logic [ADDER_WIDTH-1:0] Sum,
  output logic                   Cout,
  output logic                   Ovf,
  output logic [ADDER_WIDTH-1:0] Sum_r,
  output logic                   Cout_r,
  output logic                   Ovf_r,
  output logic                   Zero_r
);

  logic [ADDER_WIDTH:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (X[i]),
      .b    (Y[i]),
      .cin  (c[i]),
      .s    (Sum[i]),
      .cout (c[i+1])
    );
  end

  assign Cout = c[ADDER_WIDTH];
  // Signed overflow: carry into MSB differs from carry out
  assign Ovf  = c[ADDER_WIDTH-1] ^ c[ADDER_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum_r  <= SUM_RST;
      Cout_r <= COUT_RST;
      Ovf_r  <= OVF_RST;
      Zero_r <= ZERO_RST;
    end else begin
      Sum_r  <= Sum;
      Cout_r <= Cout;
      Ovf_r  <= Ovf;
      Zero_r <= (Sum == '0);
    end
  end

endmodule

// File: tb/tb_fourbit_ripple.sv
// Self-checking bench for fourbit_ripple.
// Expected values come from an arithmetic model via a queue.
module tb_fourbit_ripple;

  logic       clk;
  logic       rst;
  logic [3:0] X, Y;
  logic       Cin;
  logic [3:0] Sum, Sum_r;
  logic       Cout, Ovf, Cout_r, Ovf_r, Zero_r;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  exp_t q[$];

  fourbit_ripple dut (
    .clk    (clk),
    .rst    (rst),
    .X      (X),
    .Y      (Y),
    .Cin    (Cin),
    .Sum    (Sum),
    .Cout   (Cout),
    .Ovf    (Ovf),
    .Sum_r  (Sum_r),
    .Cout_r (Cout_r),
    .Ovf_r  (Ovf_r),
    .Zero_r (Zero_r)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [3:0] x, input logic [3:0] y,
                                 input logic ci);
    exp_t       e;
    logic [4:0] u;
    int         s;
    u = {1'b0, x} + {1'b0, y} + {4'b0, ci};
    s = int'($signed(x)) + int'($signed(y)) + int'(ci);
    e.sum  = u[3:0];
    e.cout = u[4];
    e.ovf  = (s > 7) || (s < -8);
    e.zero = (u[3:0] == 4'd0);
    return e;
  endfunction

  task automatic check_comb(input string name, input exp_t e);
    checks++;
    if ({Cout, Sum, Ovf} !== {e.cout, e.sum, e.ovf}) begin
      errors++;
      $display("FAIL %s: got cout=%b sum=%0d ovf=%b, want cout=%b sum=%0d ovf=%b",
               name, Cout, Sum, Ovf, e.cout, e.sum, e.ovf);
    end
  endtask

  task automatic check_reg(input string name, input exp_t e);
    checks++;
    if ({Cout_r, Sum_r, Ovf_r, Zero_r} !== {e.cout, e.sum, e.ovf, e.zero}) begin
      errors++;
      $display("FAIL %s: got cout_r=%b sum_r=%0d ovf_r=%b zero_r=%b, want %b %0d %b %b",
               name, Cout_r, Sum_r, Ovf_r, Zero_r, e.cout, e.sum, e.ovf, e.zero);
    end
  endtask

  task automatic drive(input logic [3:0] x, input logic [3:0] y,
                       input logic ci);
    X = x; Y = y; Cin = ci;
    q.push_back(model(x, y, ci));
  endtask

  task automatic reg_cycle(input string name, input logic [3:0] x,
                           input logic [3:0] y, input logic ci);
    exp_t e;
    @(negedge clk);
    drive(x, y, ci);
    #1;
    check_comb({name, "_comb"}, q[$]);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_reg({name, "_reg"}, e);
  endtask

  task automatic test_reset();
    exp_t r;
    r.sum = 4'd0; r.cout = 1'b0; r.ovf = 1'b0; r.zero = 1'b1;
    rst = 1'b1;
    X = 4'd9; Y = 4'd2; Cin = 1'b0;
    #1;
    check_reg("reset_async", r);
    repeat (2) @(posedge clk);
    #1;
    check_reg("reset_hold", r);
    check_comb("reset_comb_live", model(4'd9, 4'd2, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reg("reset_release_no_edge", r);
    @(posedge clk);
    #1;
    check_reg("reset_first_capture", model(4'd9, 4'd2, 1'b0));
  endtask

  task automatic test_exhaustive();
    exp_t e;
    for (int i = 0; i < 512; i++) begin
      drive(4'(i >> 5), 4'(i >> 1), i[0]);
      #10;
      e = q.pop_front();
      check_comb($sformatf("exh_%0d", i), e);
    end
  endtask

  task automatic test_overflow();
    reg_cycle("ovf_7p1", 4'd7, 4'd1, 1'b0);
    reg_cycle("ovf_neg", 4'd8, 4'd8, 1'b0);
  endtask

  task automatic test_carry_chain();
    reg_cycle("chain_15p0p1", 4'd15, 4'd0, 1'b1);
    reg_cycle("wrap_15p15p1", 4'd15, 4'd15, 1'b1);
  endtask

  task automatic test_reset_mid();
    exp_t r;
    r.sum = 4'd0; r.cout = 1'b0; r.ovf = 1'b0; r.zero = 1'b1;
    reg_cycle("mid_pre9", 4'd4, 4'd5, 1'b0);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reg("mid_async_clear", r);
    drive(4'd6, 4'd1, 1'b1);
    #1;
    check_comb("mid_comb_track", q.pop_front());
    @(posedge clk);
    #1;
    check_reg("mid_hold", r);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reg("mid_first_capture", model(4'd6, 4'd1, 1'b1));
  endtask

  task automatic test_latency();
    exp_t e7;
    reg_cycle("lat_3p4", 4'd3, 4'd4, 1'b0);
    e7 = model(4'd3, 4'd4, 1'b0);
    @(negedge clk);
    drive(4'd5, 4'd5, 1'b0);
    #1;
    check_reg("lat_still7", e7);
    @(posedge clk);
    #1;
    check_reg("lat_now10", q.pop_front());
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(4'($urandom_range(15)), 4'($urandom_range(15)),
            1'($urandom_range(1)));
      @(posedge clk);
      #1;
      e = q.pop_front();
      check_reg($sformatf("b2b_%0d", i), e);
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_overflow();
    test_carry_chain();
    test_reset_mid();
    test_latency();
    test_back_to_back();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
